// File: rtl/idecode.sv
// RISC-V ID stage: register file with write-through, main/ALU decoders,
// immediate generation and the ID/EX pipeline register.
module idecode (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] InstrD,
   input  logic [31:0] PCD,
   input  logic [31:0] PCPlus4D,
   input  logic        RegWriteW,
   input  logic [4:0]  RdW,
   input  logic [31:0] ResultW,
   input  logic        FlushE,
   output logic        RegWriteE,
   output logic        MemWriteE,
   output logic        JumpE,
   output logic        BranchE,
   output logic        ALUSrcE,
   output logic [1:0]  ResultSrcE,
   output logic [2:0]  ALUControlE,
   output logic [31:0] RD1E,
   output logic [31:0] RD2E,
   output logic [31:0] ImmExtE,
   output logic [31:0] PCE,
   output logic [31:0] PCPlus4E,
   output logic [4:0]  Rs1E,
   output logic [4:0]  Rs2E,
   output logic [4:0]  RdE,
   output logic        IllegalE
);
   localparam logic [2:0] IMM_NONE = 3'd0;
   localparam logic [2:0] IMM_I    = 3'd1;
   localparam logic [2:0] IMM_S    = 3'd2;
   localparam logic [2:0] IMM_B    = 3'd3;
   localparam logic [2:0] IMM_J    = 3'd4;

   logic [6:0]  op;
   logic [2:0]  funct3;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] rf [32];
   logic [31:0] rd1, rd2, imm_ext;

   logic        reg_write, mem_write, jump, branch, alu_src, illegal_op, illegal_f3;
   logic [1:0]  result_src, alu_op;
   logic [2:0]  imm_src, alu_ctrl;

   assign op     = InstrD[6:0];
   assign funct3 = InstrD[14:12];
   assign rs1    = InstrD[19:15];
   assign rs2    = InstrD[24:20];
   assign rd     = InstrD[11:7];

   // x0 is never written, so it stays at its reset value of zero
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (RegWriteW && RdW != 5'd0) begin
         rf[RdW] <= ResultW;
      end
   end

   always_comb begin
      rd1 = rf[rs1];
      rd2 = rf[rs2];
      if (RegWriteW && RdW != 5'd0 && RdW == rs1) rd1 = ResultW;
      if (RegWriteW && RdW != 5'd0 && RdW == rs2) rd2 = ResultW;
      if (rs1 == 5'd0) rd1 = '0;
      if (rs2 == 5'd0) rd2 = '0;
   end

   always_comb begin
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      jump       = 1'b0;
      branch     = 1'b0;
      alu_src    = 1'b0;
      result_src = 2'b00;
      alu_op     = 2'b00;
      imm_src    = IMM_NONE;
      illegal_op = 1'b0;
      case (op)
         7'b0000011: begin reg_write = 1'b1; imm_src = IMM_I; alu_src = 1'b1; result_src = 2'b01; end
         7'b0100011: begin imm_src = IMM_S; alu_src = 1'b1; mem_write = 1'b1; end
         7'b0110011: begin reg_write = 1'b1; alu_op = 2'b10; end
         7'b0010011: begin reg_write = 1'b1; imm_src = IMM_I; alu_src = 1'b1; alu_op = 2'b10; end
         7'b1100011: begin imm_src = IMM_B; branch = 1'b1; alu_op = 2'b01; end
         7'b1101111: begin reg_write = 1'b1; imm_src = IMM_J; result_src = 2'b10; jump = 1'b1; end
         default:    illegal_op = (InstrD != 32'd0);
      endcase
   end

   // Only R-type (op[5]=1) distinguishes sub from add via bit 30
   always_comb begin
      alu_ctrl   = 3'b000;
      illegal_f3 = 1'b0;
      case (alu_op)
         2'b01: alu_ctrl = 3'b001;
         2'b10: begin
            case (funct3)
               3'b000:  alu_ctrl = (op[5] && InstrD[30]) ? 3'b001 : 3'b000;
               3'b010:  alu_ctrl = 3'b101;
               3'b110:  alu_ctrl = 3'b011;
               3'b111:  alu_ctrl = 3'b010;
               default: illegal_f3 = 1'b1;
            endcase
         end
         default: alu_ctrl = 3'b000;
      endcase
   end

   always_comb begin
      case (imm_src)
         IMM_I:   imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
         IMM_S:   imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
         IMM_B:   imm_ext = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
         IMM_J:   imm_ext = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
         default: imm_ext = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset || FlushE) begin
         RegWriteE   <= 1'b0;
         MemWriteE   <= 1'b0;
         JumpE       <= 1'b0;
         BranchE     <= 1'b0;
         ALUSrcE     <= 1'b0;
         ResultSrcE  <= 2'b00;
         ALUControlE <= 3'b000;
         RD1E        <= '0;
         RD2E        <= '0;
         ImmExtE     <= '0;
         PCE         <= '0;
         PCPlus4E    <= '0;
         Rs1E        <= '0;
         Rs2E        <= '0;
         RdE         <= '0;
         IllegalE    <= 1'b0;
      end else begin
         RegWriteE   <= reg_write;
         MemWriteE   <= mem_write;
         JumpE       <= jump;
         BranchE     <= branch;
         ALUSrcE     <= alu_src;
         ResultSrcE  <= result_src;
         ALUControlE <= alu_ctrl;
         RD1E        <= rd1;
         RD2E        <= rd2;
         ImmExtE     <= imm_ext;
         PCE         <= PCD;
         PCPlus4E    <= PCPlus4D;
         Rs1E        <= rs1;
         Rs2E        <= rs2;
         RdE         <= rd;
         IllegalE    <= illegal_op | illegal_f3;
      end
   end
endmodule

// File: tb/tb_idecode.sv
// Bench for idecode: directed vector table, reset/flush sequences and
// randomized instructions checked against an instruction-level model.
module tb_idecode;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
   logic        RegWriteW, FlushE;
   logic [4:0]  RdW;
   logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE;
   logic [1:0]  ResultSrcE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
   logic [4:0]  Rs1E, Rs2E, RdE;

   idecode dut (
      .clk(clk), .reset(reset), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .FlushE(FlushE),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
      .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
      .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
      .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .IllegalE(IllegalE)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic regw, memw, jump, branch, alusrc;
      logic [1:0] rsrc;
      logic [2:0] aluc;
      logic ill;
      logic [31:0] imm, rd1, rd2, pc, pc4;
      logic [4:0] rs1, rs2, rd;
   } out_t;

   typedef struct {
      logic [31:0] instr;
      logic        rww;
      logic [4:0]  rdw;
      logic [31:0] resw;
      logic        flush;
      logic [10:0] ctrl;   // {regw,memw,jump,branch,alusrc,rsrc,aluc,ill}
      logic [31:0] imm, rd1, rd2;
   } vec_t;

   int compared = 0, mismatched = 0;
   logic [31:0] regs [32];
   out_t exp_o, got;
   vec_t vt [13];

   function automatic logic [10:0] ctl(input out_t o);
      return {o.regw, o.memw, o.jump, o.branch, o.alusrc, o.rsrc, o.aluc, o.ill};
   endfunction

   // Instruction-level meaning of each mnemonic; immediates built arithmetically
   function automatic out_t model(input logic [31:0] ins);
      out_t o = '0;
      logic [6:0] op = ins[6:0];
      logic [2:0] f3 = ins[14:12];
      int s = ins[31] ? 1 : 0;
      logic [31:0] imm_i = ins[30:20] - s * 2048;
      logic [31:0] imm_s = ins[30:25] * 32 + ins[11:7] - s * 2048;
      logic [31:0] imm_b = ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2 - s * 4096;
      logic [31:0] imm_j = ins[19:12] * 4096 + ins[20] * 2048 + ins[30:21] * 2 - s * (1 << 20);
      bit alu_fmt = 1'b0;
      if (op == 7'h03)      begin o.regw = 1; o.alusrc = 1; o.rsrc = 2'b01; o.imm = imm_i; end
      else if (op == 7'h23) begin o.memw = 1; o.alusrc = 1; o.imm = imm_s; end
      else if (op == 7'h33) begin o.regw = 1; alu_fmt = 1'b1; end
      else if (op == 7'h13) begin o.regw = 1; o.alusrc = 1; o.imm = imm_i; alu_fmt = 1'b1; end
      else if (op == 7'h63) begin o.branch = 1; o.aluc = 3'b001; o.imm = imm_b; end
      else if (op == 7'h6F) begin o.regw = 1; o.jump = 1; o.rsrc = 2'b10; o.imm = imm_j; end
      else o.ill = (ins != 0);
      if (alu_fmt) begin
         if (f3 == 3'b000)      o.aluc = (op == 7'h33 && ins[30]) ? 3'b001 : 3'b000;
         else if (f3 == 3'b010) o.aluc = 3'b101;
         else if (f3 == 3'b110) o.aluc = 3'b011;
         else if (f3 == 3'b111) o.aluc = 3'b010;
         else o.ill = 1'b1;
      end
      o.rs1 = ins[19:15];
      o.rs2 = ins[24:20];
      o.rd  = ins[11:7];
      return o;
   endfunction

   function automatic logic [31:0] rd_model(input logic [4:0] r, input logic w,
                                            input logic [4:0] wr, input logic [31:0] wd);
      if (r == 0) return 32'd0;
      if (w && wr == r) return wd;
      return regs[r];
   endfunction

   // Present one ID cycle, advance an edge, sample #1 later
   task automatic apply(input logic [31:0] ins, input logic [31:0] pc, input logic w,
                        input logic [4:0] wr, input logic [31:0] wd, input logic fl);
      InstrD = ins; PCD = pc; PCPlus4D = pc + 4;
      RegWriteW = w; RdW = wr; ResultW = wd; FlushE = fl;
      exp_o = model(ins);
      exp_o.rd1 = rd_model(ins[19:15], w, wr, wd);
      exp_o.rd2 = rd_model(ins[24:20], w, wr, wd);
      exp_o.pc = pc; exp_o.pc4 = pc + 4;
      if (fl) exp_o = '0;
      @(posedge clk);
      if (w && wr != 0) regs[wr] = wd;
      #1;
      got = {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE, IllegalE,
             ImmExtE, RD1E, RD2E, PCE, PCPlus4E, Rs1E, Rs2E, RdE};
   endtask

   task automatic check(input string name, input logic [185:0] a, input logic [185:0] e);
      compared++;
      if (a !== e) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, a, e);
      end
   endtask

   initial begin
      vt[0]  = '{32'h00500093, 0, 5'd0, 32'h0,    0, 11'b1_0_0_0_1_00_000_0, 32'd5,        32'h0,    32'h0};
      vt[1]  = '{32'h402081B3, 1, 5'd1, 32'h1234, 0, 11'b1_0_0_0_0_00_001_0, 32'd0,        32'h1234, 32'h0};
      vt[2]  = '{32'h0020A623, 0, 5'd0, 32'h0,    0, 11'b0_1_0_0_1_00_000_0, 32'd12,       32'h1234, 32'h0};
      vt[3]  = '{32'hFFDFF0EF, 0, 5'd0, 32'h0,    0, 11'b1_0_1_0_0_10_000_0, 32'hFFFFFFFC, 32'h0,    32'h0};
      vt[4]  = '{32'h00208463, 0, 5'd0, 32'h0,    0, 11'b0_0_0_1_0_00_001_0, 32'd8,        32'h1234, 32'h0};
      vt[5]  = '{32'h0000007F, 0, 5'd0, 32'h0,    0, 11'b0_0_0_0_0_00_000_1, 32'd0,        32'h0,    32'h0};
      vt[6]  = '{32'h00000000, 0, 5'd0, 32'h0,    0, 11'b0_0_0_0_0_00_000_0, 32'd0,        32'h0,    32'h0};
      vt[7]  = '{32'h0040A283, 1, 5'd2, 32'hCAFE, 1, 11'b0_0_0_0_0_00_000_0, 32'd0,        32'h0,    32'h0};
      vt[8]  = '{32'h00208333, 0, 5'd0, 32'h0,    0, 11'b1_0_0_0_0_00_000_0, 32'd0,        32'h1234, 32'hCAFE};
      vt[9]  = '{32'h00001013, 0, 5'd0, 32'h0,    0, 11'b1_0_0_0_1_00_000_1, 32'd0,        32'h0,    32'h0};
      vt[10] = '{32'hFFF0A093, 0, 5'd0, 32'h0,    0, 11'b1_0_0_0_1_00_101_0, 32'hFFFFFFFF, 32'h1234, 32'h0};
      vt[11] = '{32'h000003B3, 1, 5'd0, 32'hDEAD, 0, 11'b1_0_0_0_0_00_000_0, 32'd0,        32'h0,    32'h0};
      vt[12] = '{32'h00006433, 0, 5'd0, 32'h0,    0, 11'b1_0_0_0_0_00_011_0, 32'd0,        32'h0,    32'h0};

      for (int i = 0; i < 32; i++) regs[i] = '0;
      reset = 1'b0; InstrD = 32'h00500093; PCD = 32'h40; PCPlus4D = 32'h44;
      RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'h55; FlushE = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      got = {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE, IllegalE,
             ImmExtE, RD1E, RD2E, PCE, PCPlus4E, Rs1E, Rs2E, RdE};
      check("reset_state", got, '0);
      @(negedge clk) reset = 1'b1;

      for (int i = 0; i < 13; i++) begin
         apply(vt[i].instr, 32'h1000 + 32'(i) * 4, vt[i].rww, vt[i].rdw, vt[i].resw, vt[i].flush);
         check($sformatf("vec%0d", i), {89'd0, ctl(got), got.imm, got.rd1, got.rd2},
               {89'd0, vt[i].ctrl, vt[i].imm, vt[i].rd1, vt[i].rd2});
         check($sformatf("vec%0d_model", i), got, exp_o);
      end

      // Async reset while RegWriteE is high; then x1 must read back as 0
      reset = 1'b0;
      #1;
      got = {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE, IllegalE,
             ImmExtE, RD1E, RD2E, PCE, PCPlus4E, Rs1E, Rs2E, RdE};
      check("async_reset", got, '0);
      for (int i = 0; i < 32; i++) regs[i] = '0;
      @(negedge clk) reset = 1'b1;
      apply(32'h00208333, 32'h2000, 0, 5'd0, 32'h0, 0);
      check("postreset_rd1", {154'd0, got.rd1}, 186'd0);
      check("postreset_model", got, exp_o);

      for (int n = 0; n < 400; n++) begin
         logic [31:0] ins;
         logic [6:0] ops [8];
         ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h00, 7'h00};
         ins = $urandom;
         ops[6] = 7'($urandom);
         ins[6:0] = ops[$urandom_range(0, 7)];
         if ($urandom_range(0, 30) == 0) ins = 32'd0;
         apply(ins, $urandom & 32'hFFFF_FFFC, ($urandom_range(0, 1) == 1), 5'($urandom),
               $urandom, ($urandom_range(0, 9) == 0));
         check($sformatf("rand%0d", n), got, exp_o);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
